ssd_hba_model: RTL and testbench

// - Behavioural SATA HBA responder: the device end of the cmd/lba/sectorcnt, rdata and wdata interfaces of mcd_ssd_inf.
// - Sector store in on-chip RAM; serves READ/WRITE commands; supports sim and bring-up of the memcached SSD path with no real drive.
// - Drives cmd_success/cmd_failed, ncq_idle and link_initialized.

---
 rtl/ssd_hba_if.sv | 43 ++++
 rtl/ssd_hba_model.sv | 155 +++++++++++++++
 tb/tb_ssd_hba_model.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_hba_if.sv
// Host <-> HBA-model command, read-data and write-data signals.
// err_inject exists only when SSD_MODEL_ERRINJ_EN is defined.
interface ssd_hba_if;
    logic [2:0]  cmd;
    logic        cmd_en;
    logic [47:0] lba;
    logic [15:0] sectorcnt;
    logic        cmd_success;
    logic        cmd_failed;
    logic        ncq_idle;
    logic        link_initialized;
    logic [31:0] rdata;
    logic        rdata_empty;
    logic        rdata_next;
    logic [31:0] wdata;
    logic        wdata_en;
    logic        wdata_full;
`ifdef SSD_MODEL_ERRINJ_EN
    logic        err_inject;

    modport master (
        output cmd, cmd_en, lba, sectorcnt, rdata_next, wdata, wdata_en, err_inject,
        input  cmd_success, cmd_failed, ncq_idle, link_initialized, rdata, rdata_empty,
               wdata_full
    );
    modport slave (
        input  cmd, cmd_en, lba, sectorcnt, rdata_next, wdata, wdata_en, err_inject,
        output cmd_success, cmd_failed, ncq_idle, link_initialized, rdata, rdata_empty,
               wdata_full
    );
`else
    modport master (
        output cmd, cmd_en, lba, sectorcnt, rdata_next, wdata, wdata_en,
        input  cmd_success, cmd_failed, ncq_idle, link_initialized, rdata, rdata_empty,
               wdata_full
    );
    modport slave (
        input  cmd, cmd_en, lba, sectorcnt, rdata_next, wdata, wdata_en,
        output cmd_success, cmd_failed, ncq_idle, link_initialized, rdata, rdata_empty,
               wdata_full
    );
`endif
endinterface

// File: rtl/ssd_hba_model.sv
// Behavioural SATA HBA device model: on-chip sector store serving READ/WRITE commands.
// Define SSD_MODEL_ERRINJ_EN to add the err_inject command-failure input.
module ssd_hba_model #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned SECTOR_WORDS = 128,
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned INIT_CYCLES  = 16
) (
    input logic      clk,
    input logic      nReset,
    ssd_hba_if.slave bus
);
    localparam int unsigned    SwLog    = $clog2(SECTOR_WORDS);
    localparam int unsigned    Depth    = 2 ** FIFO_AW;
    localparam int unsigned    CntW     = FIFO_AW + 1;
    localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
    localparam logic [2:0]     CmdRead  = 3'd1;
    localparam logic [2:0]     CmdWrite = 3'd2;

    typedef enum logic [2:0] {StInit, StIdle, StRd, StWr, StDone, StFail} state_e;

    state_e             state_q, state_d;
    logic [31:0]        init_cnt_q, init_cnt_d;
    logic               link_q, link_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [31:0]        total_q, total_d;
    logic [31:0]        idx_q, idx_d;

    logic [31:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_re, ram_we;
    logic [31:0]        ram_rdata_q;
    logic               rd_vld_q;

    logic [31:0]        rfifo [Depth];
    logic [FIFO_AW-1:0] rwp_q, rrp_q;
    logic [CntW-1:0]    rcnt_q, rcnt_next;
    logic               rpush, rpop;

    logic [31:0]        wfifo [Depth];
    logic [FIFO_AW-1:0] wwp_q, wrp_q;
    logic [CntW-1:0]    wcnt_q;
    logic               wpush, wpop;

    logic               inject, cmd_bad, unused_lba;

`ifdef SSD_MODEL_ERRINJ_EN
    assign inject = bus.err_inject;
`else
    assign inject = 1'b0;
`endif
    assign cmd_bad = inject || (bus.sectorcnt == '0) ||
                     (bus.cmd != CmdRead && bus.cmd != CmdWrite);
    assign unused_lba = ^bus.lba[47:ADDR_W-SwLog];

    assign ram_addr  = base_q + idx_q[ADDR_W-1:0];
    assign rpush     = rd_vld_q;
    assign rpop      = bus.rdata_next && (rcnt_q != '0);
    assign rcnt_next = rcnt_q + CntW'(rpush) - CntW'(rpop);
    // Issue only if the word will find room when it lands next cycle.
    assign ram_re    = (state_q == StRd) && (idx_q != total_q) && (rcnt_next < DepthC);
    assign wpop      = (state_q == StWr) && (wcnt_q != '0);
    assign ram_we    = wpop;
    assign wpush     = bus.wdata_en && ((wcnt_q != DepthC) || wpop);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        link_d     = link_q;
        base_d     = base_q;
        total_d    = total_q;
        idx_d      = idx_q;
        unique case (state_q)
            StInit: begin
                if (init_cnt_q == INIT_CYCLES) begin
                    state_d = StIdle;
                    link_d  = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 32'd1;
                end
            end
            StIdle: begin
                if (bus.cmd_en) begin
                    base_d  = {bus.lba[ADDR_W-SwLog-1:0], {SwLog{1'b0}}};
                    total_d = 32'({bus.sectorcnt, {SwLog{1'b0}}});
                    idx_d   = '0;
                    if (cmd_bad)                 state_d = StFail;
                    else if (bus.cmd == CmdRead) state_d = StRd;
                    else                         state_d = StWr;
                end
            end
            StRd: begin
                if (ram_re) idx_d = idx_q + 32'd1;
                // All reads issued and the final one is landing now.
                if (rd_vld_q && (idx_q == total_q)) state_d = StDone;
            end
            StWr: begin
                if (wpop) begin
                    idx_d = idx_q + 32'd1;
                    if (idx_q == total_q - 32'd1) state_d = StDone;
                end
            end
            StDone, StFail: state_d = StIdle;
            default:        state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            link_q     <= 1'b0;
            base_q     <= '0;
            total_q    <= '0;
            idx_q      <= '0;
            rd_vld_q   <= 1'b0;
            rwp_q      <= '0;
            rrp_q      <= '0;
            rcnt_q     <= '0;
            wwp_q      <= '0;
            wrp_q      <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            link_q     <= link_d;
            base_q     <= base_d;
            total_q    <= total_d;
            idx_q      <= idx_d;
            rd_vld_q   <= ram_re;
            rcnt_q     <= rcnt_next;
            wcnt_q     <= wcnt_q + CntW'(wpush) - CntW'(wpop);
            if (rpush) rwp_q <= rwp_q + 1'b1;
            if (rpop)  rrp_q <= rrp_q + 1'b1;
            if (wpush) wwp_q <= wwp_q + 1'b1;
            if (wpop)  wrp_q <= wrp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= wfifo[wrp_q];
        if (ram_re) ram_rdata_q <= mem[ram_addr];
        if (rpush)  rfifo[rwp_q] <= ram_rdata_q;
        if (wpush)  wfifo[wwp_q] <= bus.wdata;
    end

    assign bus.cmd_success      = (state_q == StDone);
    assign bus.cmd_failed       = (state_q == StFail);
    assign bus.ncq_idle         = (state_q == StIdle);
    assign bus.link_initialized = link_q;
    assign bus.rdata_empty      = (rcnt_q == '0);
    // Gate the head so the port reads 0 rather than stale storage when empty.
    assign bus.rdata            = (rcnt_q == '0) ? 32'd0 : rfifo[rrp_q];
    assign bus.wdata_full       = (wcnt_q == DepthC);
endmodule

// File: tb/tb_ssd_hba_model.sv
// Directed self-checking bench for ssd_hba_model (default parameters).
// Builds with or without SSD_MODEL_ERRINJ_EN.
module tb_ssd_hba_model;
    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] rd_buf[$];

    always #5 clk = ~clk;

    ssd_hba_if bus ();
    ssd_hba_model dut (.clk(clk), .nReset(nReset), .bus(bus));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [47:0] l, input logic [15:0] n);
        for (int i = 0; i < 50 && !bus.ncq_idle; i++) tick();
        bus.cmd = c; bus.lba = l; bus.sectorcnt = n; bus.cmd_en = 1'b1;
        tick();
        bus.cmd_en = 1'b0;
    endtask

    task automatic write_cmd(input logic [47:0] l, input logic [15:0] n, input logic [31:0] d0,
                             output int succ);
        succ = 0;
        issue(3'd2, l, n);
        for (int i = 0; i < int'(n) * 128; i++) begin
            bus.wdata = d0 + 32'(i); bus.wdata_en = 1'b1;
            tick();
            succ += int'(bus.cmd_success);
        end
        bus.wdata_en = 1'b0;
        for (int c = 0; c < 20 && succ == 0; c++) begin
            tick();
            succ += int'(bus.cmd_success);
        end
    endtask

    task automatic drain_read(output int succ);
        succ = 0;
        rd_buf.delete();
        for (int c = 0; c < 4000; c++) begin
            succ += int'(bus.cmd_success);
            if (!bus.rdata_empty) begin
                rd_buf.push_back(bus.rdata); bus.rdata_next = 1'b1;
            end else begin
                bus.rdata_next = 1'b0;
            end
            if (succ != 0 && bus.rdata_empty) break;
            tick();
        end
        bus.rdata_next = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if ({bus.cmd_success, bus.cmd_failed, bus.ncq_idle, bus.link_initialized,
             bus.rdata_empty, bus.wdata_full} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000010", {bus.cmd_success, bus.cmd_failed,
                     bus.ncq_idle, bus.link_initialized, bus.rdata_empty, bus.wdata_full});
        end
        n_checks++;
        if (bus.rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
        end
    endtask

    task automatic test_init();
        int pulses = 0;
        nReset = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            if (k == 5) begin
                bus.cmd = 3'd1; bus.lba = '0; bus.sectorcnt = 16'd1; bus.cmd_en = 1'b1;
            end
            tick();
            bus.cmd_en = 1'b0;
            pulses += int'(bus.cmd_success) + int'(bus.cmd_failed);
            if (k == 16) begin
                n_checks++;
                if (bus.link_initialized !== 1'b0) begin
                    n_fail++; $display("FAIL link_early: got %b want 0", bus.link_initialized);
                end
            end
        end
        n_checks++;
        if (bus.link_initialized !== 1'b1 || bus.ncq_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL link_rise: got link=%b idle=%b want 1 1", bus.link_initialized,
                     bus.ncq_idle);
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL init_cmd_ignored: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_write_read();
        int succ, rsucc;
        write_cmd(48'd2, 16'd1, 32'h100, succ);
        n_checks++;
        if (succ != 1) begin
            n_fail++; $display("FAIL wr_success: got %0d pulses want 1", succ);
        end
        issue(3'd1, 48'd2, 16'd1);
        drain_read(rsucc);
        n_checks++;
        if (rsucc != 1 || rd_buf.size() != 128) begin
            n_fail++;
            $display("FAIL rd_success: got %0d pulses %0d words want 1 128", rsucc, rd_buf.size());
        end
        for (int i = 0; i < rd_buf.size(); i++) begin
            n_checks++;
            if (rd_buf[i] !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL rd_word[%0d]: got %h want %h", i, rd_buf[i], 32'h100 + i);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  cmds[2] = '{3'd1, 3'd5};
        logic [15:0] cnts[2] = '{16'd0, 16'd1};
        for (int t = 0; t < 2; t++) begin
            issue(cmds[t], 48'd2, cnts[t]);
            n_checks++;
            if (bus.cmd_failed !== 1'b1 || bus.ncq_idle !== 1'b0 || bus.cmd_success !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal%0d_pulse: got fail=%b idle=%b ok=%b want 1 0 0", t,
                         bus.cmd_failed, bus.ncq_idle, bus.cmd_success);
            end
            tick();
            n_checks++;
            if (bus.cmd_failed !== 1'b0 || bus.ncq_idle !== 1'b1 || bus.rdata_empty !== 1'b1 ||
                bus.wdata_full !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal%0d_after: got fail=%b idle=%b empty=%b full=%b want 0 1 1 0",
                         t, bus.cmd_failed, bus.ncq_idle, bus.rdata_empty, bus.wdata_full);
            end
        end
    endtask

    task automatic test_backpressure();
        int succ, stall_succ = 0, bad = 0;
        write_cmd(48'd4, 16'd2, 32'hA000, succ);
        n_checks++;
        if (succ != 1) begin
            n_fail++; $display("FAIL bp_write: got %0d pulses want 1", succ);
        end
        bus.rdata_next = 1'b0;
        issue(3'd1, 48'd4, 16'd2);
        for (int c = 0; c < 40; c++) begin
            tick();
            stall_succ += int'(bus.cmd_success);
        end
        n_checks++;
        if (stall_succ != 0 || bus.ncq_idle !== 1'b0 || bus.rdata !== 32'hA000) begin
            n_fail++;
            $display("FAIL bp_stall: got pulses=%0d idle=%b head=%h want 0 0 0000a000",
                     stall_succ, bus.ncq_idle, bus.rdata);
        end
        drain_read(succ);
        n_checks++;
        if (succ != 1 || rd_buf.size() != 256) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pulses %0d words want 1 256", succ, rd_buf.size());
        end
        for (int i = 0; i < rd_buf.size(); i++) bad += int'(rd_buf[i] !== 32'hA000 + 32'(i));
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_data: got %0d wrong words want 0", bad);
        end
    endtask

    task automatic test_wdata_overflow();
        int succ = 0, bad = 0;
        logic [31:0] exp_w;
        for (int i = 1; i <= 20; i++) begin
            bus.wdata = 32'h200 + 32'(i - 1); bus.wdata_en = 1'b1;
            tick();
            if (i == 15 || i == 16) begin
                n_checks++;
                if (bus.wdata_full !== (i == 16)) begin
                    n_fail++;
                    $display("FAIL wfull_after_%0d: got %b want %b", i, bus.wdata_full, i == 16);
                end
            end
        end
        bus.wdata_en = 1'b0;
        issue(3'd2, 48'd6, 16'd1);
        tick();
        n_checks++;
        if (bus.wdata_full !== 1'b0) begin
            n_fail++; $display("FAIL wfull_drop: got %b want 0", bus.wdata_full);
        end
        for (int i = 0; i < 112; i++) begin
            bus.wdata = 32'h300 + 32'(i); bus.wdata_en = 1'b1;
            tick();
            succ += int'(bus.cmd_success);
        end
        bus.wdata_en = 1'b0;
        for (int c = 0; c < 20 && succ == 0; c++) begin
            tick();
            succ += int'(bus.cmd_success);
        end
        n_checks++;
        if (succ != 1) begin
            n_fail++; $display("FAIL ovf_write: got %0d pulses want 1", succ);
        end
        issue(3'd1, 48'd6, 16'd1);
        drain_read(succ);
        for (int i = 0; i < rd_buf.size(); i++) begin
            exp_w = (i < 16) ? 32'h200 + 32'(i) : 32'h300 + 32'(i - 16);
            bad += int'(rd_buf[i] !== exp_w);
        end
        n_checks++;
        if (bad != 0 || rd_buf.size() != 128) begin
            n_fail++;
            $display("FAIL ovf_data: got %0d wrong of %0d words want 0 of 128", bad, rd_buf.size());
        end
    endtask

    task automatic test_errinj();
`ifdef SSD_MODEL_ERRINJ_EN
        for (int i = 0; i < 3; i++) begin
            bus.wdata = 32'h400 + 32'(i); bus.wdata_en = 1'b1;
            tick();
        end
        bus.wdata_en = 1'b0;
        bus.err_inject = 1'b1;
        issue(3'd2, 48'd8, 16'd1);
        bus.err_inject = 1'b0;
        n_checks++;
        if (bus.cmd_failed !== 1'b1) begin
            n_fail++; $display("FAIL errinj_pulse: got %b want 1", bus.cmd_failed);
        end
        tick();
        for (int i = 1; i <= 13; i++) begin
            bus.wdata = 32'h500 + 32'(i); bus.wdata_en = 1'b1;
            tick();
            if (i == 12 || i == 13) begin
                n_checks++;
                if (bus.wdata_full !== (i == 13)) begin
                    n_fail++;
                    $display("FAIL errinj_occ_%0d: got full=%b want %b", i, bus.wdata_full,
                             i == 13);
                end
            end
        end
        bus.wdata_en = 1'b0;
`endif
    endtask

    task automatic test_async_reset();
        issue(3'd1, 48'd4, 16'd2);
        bus.rdata_next = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.wdata = 32'h600; bus.wdata_en = (c < 2);
            tick();
        end
        bus.wdata_en = 1'b0;
        n_checks++;
        if (bus.ncq_idle !== 1'b0 || bus.rdata_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: got idle=%b empty=%b want 0 0", bus.ncq_idle,
                     bus.rdata_empty);
        end
        #3 nReset = 1'b0;
        #1;
        n_checks++;
        if ({bus.cmd_success, bus.cmd_failed, bus.ncq_idle, bus.link_initialized,
             bus.rdata_empty, bus.wdata_full} !== 6'b000010 || bus.rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got flags %b rdata %h want 000010 0",
                     {bus.cmd_success, bus.cmd_failed, bus.ncq_idle, bus.link_initialized,
                      bus.rdata_empty, bus.wdata_full}, bus.rdata);
        end
        tick();
        nReset = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                n_checks++;
                if (bus.link_initialized !== 1'b0 || bus.ncq_idle !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reinit_early: got link=%b idle=%b want 0 0",
                             bus.link_initialized, bus.ncq_idle);
                end
            end
        end
        n_checks++;
        if (bus.link_initialized !== 1'b1 || bus.rdata_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reinit_done: got link=%b empty=%b want 1 1", bus.link_initialized,
                     bus.rdata_empty);
        end
    endtask

    initial begin
        bus.cmd = '0; bus.cmd_en = 1'b0; bus.lba = '0; bus.sectorcnt = '0;
        bus.rdata_next = 1'b0; bus.wdata = '0; bus.wdata_en = 1'b0;
`ifdef SSD_MODEL_ERRINJ_EN
        bus.err_inject = 1'b0;
`endif
        test_reset();
        test_init();
        test_write_read();
        test_illegal();
        test_backpressure();
        test_wdata_overflow();
        test_errinj();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
